// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply sequencer driving one external monpro
// Computes C = M^e mod N with a fixed DATAWIDTH-bit exponent scan, entirely in the Montgomery domain.
module modexp_ctrl #(
  parameter int DATAWIDTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] i_M,
  input  logic [DATAWIDTH-1:0] i_E,
  input  logic [DATAWIDTH-1:0] i_N,
  input  logic [DATAWIDTH-1:0] i_R2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] o_C,
  output logic                 mp_start,
  input  logic                 mp_ready,
  input  logic                 mp_valid,
  output logic [DATAWIDTH-1:0] mp_A,
  output logic [DATAWIDTH-1:0] mp_B,
  output logic [DATAWIDTH-1:0] mp_N,
  input  logic [DATAWIDTH-1:0] mp_U
);

  localparam int IW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_M = 3'd1,
    PRE_X = 3'd2,
    SQR   = 3'd3,
    MUL   = 3'd4,
    POST  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] op_a;
  logic [DATAWIDTH-1:0] op_b;
  logic [DATAWIDTH-1:0] mbar;
  logic [DATAWIDTH-1:0] e_reg;
  logic [DATAWIDTH-1:0] n_reg;
  logic [DATAWIDTH-1:0] r2_reg;
  logic [IW-1:0]        idx;
  logic                 issued;
  logic                 op_state;
  logic                 last_bit;

  assign op_state = (state == PRE_M) || (state == PRE_X) || (state == SQR) ||
                    (state == MUL)   || (state == POST);
  assign last_bit = (idx == '0);

  // Start fires in the first cycle the op state sees monpro idle; issued blocks any repeat.
  assign mp_start = op_state & ~issued & mp_ready;
  assign mp_A     = op_a;
  assign mp_B     = op_b;
  assign mp_N     = n_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      o_C       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      mbar      <= '0;
      e_reg     <= '0;
      n_reg     <= '0;
      r2_reg    <= '0;
      idx       <= '0;
      issued    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            e_reg    <= i_E;
            n_reg    <= i_N;
            r2_reg   <= i_R2;
            op_a     <= i_M;
            op_b     <= i_R2;
            idx      <= IW'(DATAWIDTH - 1);
            issued   <= 1'b0;
            in_ready <= 1'b0;
            state    <= PRE_M;
          end
        end

        PRE_M, PRE_X, SQR, MUL, POST: begin
          if (mp_start) begin
            issued <= 1'b1;
          end else if (issued && mp_valid) begin
            issued <= 1'b0;
            // Operands for the next op are loaded on the same edge the result lands.
            case (state)
              PRE_M: begin
                mbar  <= mp_U;
                op_a  <= ONE;
                op_b  <= r2_reg;
                state <= PRE_X;
              end
              PRE_X: begin
                op_a  <= mp_U;
                op_b  <= mp_U;
                state <= SQR;
              end
              SQR: begin
                op_a <= mp_U;
                if (e_reg[idx]) begin
                  op_b  <= mbar;
                  state <= MUL;
                end else if (last_bit) begin
                  op_b  <= ONE;
                  state <= POST;
                end else begin
                  op_b  <= mp_U;
                  idx   <= idx - IW'(1);
                  state <= SQR;
                end
              end
              MUL: begin
                op_a <= mp_U;
                if (last_bit) begin
                  op_b  <= ONE;
                  state <= POST;
                end else begin
                  op_b  <= mp_U;
                  idx   <= idx - IW'(1);
                  state <= SQR;
                end
              end
              default: begin
                o_C       <= mp_U;
                out_valid <= 1'b1;
                state     <= DONE;
              end
            endcase
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          issued    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - scoreboard bench for modexp_ctrl at 16 and 256 bits
// Each DUT drives a behavioural radix-2 Montgomery product model with fixed latency.
module tb_modexp_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        in_valid_s = 1'b0, in_ready_s, out_valid_s, out_ready_s = 1'b1;
  logic [15:0] i_M_s = '0, i_E_s = '0, i_N_s = 16'h00F1, i_R2_s = 16'h000F, o_C_s;
  logic        mp_start_s, mp_ready_s, mp_valid_s;
  logic [15:0] mp_A_s, mp_B_s, mp_N_s, mp_U_s;

  // 256-bit instance
  logic         in_valid_w = 1'b0, in_ready_w, out_valid_w, out_ready_w = 1'b1;
  logic [255:0] i_M_w = '0, i_E_w = '0, i_N_w = '0, i_R2_w = '0, o_C_w;
  logic         mp_start_w, mp_ready_w, mp_valid_w;
  logic [255:0] mp_A_w, mp_B_w, mp_N_w, mp_U_w;

  modexp_ctrl #(.DATAWIDTH(16)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .i_M(i_M_s), .i_E(i_E_s), .i_N(i_N_s), .i_R2(i_R2_s),
    .out_valid(out_valid_s), .out_ready(out_ready_s), .o_C(o_C_s),
    .mp_start(mp_start_s), .mp_ready(mp_ready_s), .mp_valid(mp_valid_s),
    .mp_A(mp_A_s), .mp_B(mp_B_s), .mp_N(mp_N_s), .mp_U(mp_U_s)
  );

  modexp_ctrl #(.DATAWIDTH(256)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .i_M(i_M_w), .i_E(i_E_w), .i_N(i_N_w), .i_R2(i_R2_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .o_C(o_C_w),
    .mp_start(mp_start_w), .mp_ready(mp_ready_w), .mp_valid(mp_valid_w),
    .mp_A(mp_A_w), .mp_B(mp_B_w), .mp_N(mp_N_w), .mp_U(mp_U_w)
  );

  function automatic logic [255:0] mont(input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] n, input int w);
    logic [257:0] u;
    u = '0;
    for (int i = 0; i < w; i++) begin
      if (a[i]) u = u + {2'b00, b};
      if (u[0]) u = u + {2'b00, n};
      u = u >> 1;
    end
    if (u >= {2'b00, n}) u = u - {2'b00, n};
    return u[255:0];
  endfunction

  function automatic logic [255:0] modmul(input logic [255:0] a, input logic [255:0] b,
                                          input logic [255:0] n);
    logic [257:0] acc;
    acc = '0;
    for (int i = 255; i >= 0; i--) begin
      acc = acc << 1;
      if (acc >= {2'b00, n}) acc = acc - {2'b00, n};
      if (b[i]) acc = acc + {2'b00, a};
      if (acc >= {2'b00, n}) acc = acc - {2'b00, n};
    end
    return acc[255:0];
  endfunction

  // Monpro models: busy for a few cycles after start, then a one-cycle result pulse.
  logic        busy_s, busy_w;
  int          lat_s, lat_w;
  logic [15:0] res_s;
  logic [255:0] res_w;
  assign mp_ready_s = ~busy_s;
  assign mp_ready_w = ~busy_w;
  assign mp_U_s     = res_s;
  assign mp_U_w     = res_w;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_s <= 1'b0; lat_s <= 0; mp_valid_s <= 1'b0; res_s <= '0;
    end else begin
      mp_valid_s <= 1'b0;
      if (!busy_s && mp_start_s) begin
        busy_s <= 1'b1;
        lat_s  <= 3;
        res_s  <= 16'(mont({240'b0, mp_A_s}, {240'b0, mp_B_s}, {240'b0, mp_N_s}, 16));
      end else if (busy_s) begin
        if (lat_s == 0) begin busy_s <= 1'b0; mp_valid_s <= 1'b1; end
        else lat_s <= lat_s - 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_w <= 1'b0; lat_w <= 0; mp_valid_w <= 1'b0; res_w <= '0;
    end else begin
      mp_valid_w <= 1'b0;
      if (!busy_w && mp_start_w) begin
        busy_w <= 1'b1;
        lat_w  <= 2;
        res_w  <= mont(mp_A_w, mp_B_w, mp_N_w, 256);
      end else if (busy_w) begin
        if (lat_w == 0) begin busy_w <= 1'b0; mp_valid_w <= 1'b1; end
        else lat_w <= lat_w - 1;
      end
    end
  end

  int starts_s = 0, starts_w = 0;
  always @(negedge clk) begin
    if (mp_start_s) starts_s <= starts_s + 1;
    if (mp_start_w) starts_w <= starts_w + 1;
  end

  typedef struct {
    logic [255:0] c;
    int           pulses;
    int           base;
  } exp_t;
  exp_t q_s[$];
  exp_t q_w[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the expected result whenever a result handshake is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_s && out_ready_s) begin
      if (q_s.size() == 0) check("unexpected_result_16", 256'(o_C_s), '1);
      else begin
        e = q_s.pop_front();
        check("result_16", 256'(o_C_s), e.c);
        check("mp_start_count_16", 256'(starts_s - e.base), 256'(e.pulses));
      end
    end
    if (!rst && out_valid_w && out_ready_w) begin
      if (q_w.size() == 0) check("unexpected_result_256", o_C_w, '1);
      else begin
        e = q_w.pop_front();
        check("result_256", o_C_w, e.c);
        check("mp_start_count_256", 256'(starts_w - e.base), 256'(e.pulses));
      end
    end
  end

  task automatic wait_in_ready_s(input int limit);
    int n = 0;
    while (!in_ready_s && n < limit) begin @(posedge clk); #1; n++; end
    if (!in_ready_s) check("timeout_in_ready_16", 256'(in_ready_s), 256'(1));
  endtask

  task automatic issue_s(input logic [15:0] m, input logic [15:0] e,
                         input logic [15:0] c, input int pulses, input bit push);
    exp_t x;
    wait_in_ready_s(5000);
    i_M_s = m; i_E_s = e; in_valid_s = 1'b1;
    if (push) begin
      x.c = 256'(c); x.pulses = pulses; x.base = starts_s;
      q_s.push_back(x);
    end
    @(posedge clk); #1;
    in_valid_s = 1'b0;
  endtask

  logic [256:0] r2tmp;
  logic [255:0] m_big, n_big, c_big;
  exp_t xw;
  int   n_wait;
  int   base0;

  initial begin
    // Reset state
    #2;
    check("rst_in_ready", 256'(in_ready_s), 256'(0));
    check("rst_out_valid", 256'(out_valid_s), 256'(0));
    check("rst_o_C", 256'(o_C_s), 256'(0));
    check("rst_mp_start", 256'(mp_start_s), 256'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 256'(in_ready_s), 256'(1));

    // Directed 16-bit vectors: N=241, R2=2^32 mod 241
    issue_s(16'h0005, 16'h0003, 16'h007D, 21, 1'b1);
    issue_s(16'h0005, 16'h0004, 16'h008F, 20, 1'b1);
    issue_s(16'h0005, 16'h00F0, 16'h0001, 23, 1'b1);
    issue_s(16'h0007, 16'h0000, 16'h0001, 19, 1'b1);
    issue_s(16'h0007, 16'h0001, 16'h0007, 20, 1'b1);

    // Result held while out_ready is low; a mid-run in_valid is ignored
    wait_in_ready_s(5000);
    out_ready_s = 1'b0;
    issue_s(16'h0005, 16'h0003, 16'h007D, 21, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    i_M_s = 16'h0033; i_E_s = 16'h0009; in_valid_s = 1'b1;
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    n_wait = 0;
    while (!out_valid_s && n_wait < 5000) begin @(posedge clk); #1; n_wait++; end
    check("hold_out_valid_seen", 256'(out_valid_s), 256'(1));
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 256'(out_valid_s), 256'(1));
      check("hold_o_C", 256'(o_C_s), 256'(16'h007D));
      check("hold_in_ready", 256'(in_ready_s), 256'(0));
    end
    out_ready_s = 1'b1;
    @(posedge clk); #1;
    check("drop_out_valid", 256'(out_valid_s), 256'(0));

    // Reset during the first MUL op (18th op of e=3), then a clean rerun
    issue_s(16'h0005, 16'h0003, 16'h0000, 0, 1'b0);
    base0 = starts_s - 1;
    n_wait = 0;
    while ((starts_s - base0) < 18 && n_wait < 5000) begin @(posedge clk); #1; n_wait++; end
    check("reached_mul", 256'(starts_s - base0 >= 18), 256'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_in_ready", 256'(in_ready_s), 256'(0));
    check("rst_mid_out_valid", 256'(out_valid_s), 256'(0));
    rst = 1'b0;
    base0 = starts_s;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_start", 256'(starts_s - base0), 256'(0));
    check("rst_in_ready_back", 256'(in_ready_s), 256'(1));
    check("rst_out_valid_low", 256'(out_valid_s), 256'(0));
    issue_s(16'h0005, 16'h0003, 16'h007D, 21, 1'b1);
    wait_in_ready_s(5000);

    // 256-bit: M^2 mod N against a shift-add reference
    m_big = 256'h1f94373be50b1cc0ced44eebde66dd7acb02d59c51941d2497184c45aab39f5f;
    n_big = 256'h2e5f7417fd9c9471c4ee1077900d7e4051e4d3f682b95bc27f5d128e05df33b5;
    r2tmp = 257'd1;
    for (int k = 0; k < 512; k++) begin
      r2tmp = r2tmp << 1;
      if (r2tmp >= {1'b0, n_big}) r2tmp = r2tmp - {1'b0, n_big};
    end
    c_big = modmul(m_big, m_big, n_big);
    n_wait = 0;
    while (!in_ready_w && n_wait < 100) begin @(posedge clk); #1; n_wait++; end
    i_M_w = m_big; i_E_w = 256'h2; i_N_w = n_big; i_R2_w = r2tmp[255:0]; in_valid_w = 1'b1;
    xw.c = c_big; xw.pulses = 260; xw.base = starts_w;
    q_w.push_back(xw);
    @(posedge clk); #1;
    in_valid_w = 1'b0;
    n_wait = 0;
    while (!(in_ready_w && q_w.size() == 0) && n_wait < 20000) begin
      @(posedge clk); #1; n_wait++;
    end
    check("done_256", 256'(q_w.size()), 256'(0));
    check("done_16", 256'(q_s.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
